// File: rtl/seg7_pkg.sv
// Shared constants for the 7-segment scan driver: hex segment table and
// polarity helpers.
package seg7_pkg;

    // Active-high segment patterns, bit6 = g ... bit0 = a, indexed by hex value.
    localparam logic [15:0][6:0] SegTable = {
        7'b1110001, 7'b1111001, 7'b1011110, 7'b0111001,
        7'b1111100, 7'b1110111, 7'b1101111, 7'b1111111,
        7'b0000111, 7'b1111101, 7'b1101101, 7'b1100110,
        7'b1001111, 7'b1011011, 7'b0000110, 7'b0111111
    };

    localparam logic [6:0] SegAllOn = 7'h7F;

    function automatic logic [6:0] seg_drive(input logic [6:0] act, input bit active_low);
        return active_low ? ~act : act;
    endfunction

    function automatic logic pol_bit(input logic act, input bit active_low);
        return act ^ active_low;
    endfunction

endpackage

// File: rtl/seg7_scan_driver_if.sv
// Host/display signal bundle for seg7_scan_driver.
interface seg7_scan_driver_if #(
    parameter int unsigned DIGITS = 4
) ();
    logic [4*DIGITS-1:0] data;
    logic [DIGITS-1:0]   dp;
    logic [DIGITS-1:0]   blank;
    logic                lz_en;
    logic                load;
    logic                pending;
    logic [6:0]          seg;
    logic                seg_dp;
    logic [DIGITS-1:0]   an;
    logic                frame;

    modport master (
        output data, dp, blank, lz_en, load,
        input  pending, seg, seg_dp, an, frame
    );

    modport slave (
        input  data, dp, blank, lz_en, load,
        output pending, seg, seg_dp, an, frame
    );
endinterface

// File: rtl/hex_seg_decode.sv
// Combinational hex nibble to active-high 7-segment decoder.
module hex_seg_decode
    import seg7_pkg::*;
(
    input  logic [3:0] nibble_i,
    output logic [6:0] seg_o
);
    assign seg_o = SegTable[nibble_i];
endmodule

// File: rtl/seg7_scan_driver.sv
// Multiplexed 7-segment display driver with double-buffered data, dead time
// between digits and leading-zero suppression.
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int unsigned DIGITS   = 4,
    parameter int unsigned SCAN_DIV = 50000,
    parameter int unsigned DEAD     = 2,
    parameter int unsigned SEG_AL   = 1,
    parameter int unsigned AN_AL    = 1
) (
    input logic               clk,
    input logic               rst_n,
    seg7_scan_driver_if.slave bus
);
    localparam int unsigned PscW   = $clog2(SCAN_DIV);
    localparam int unsigned IdxW   = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam bit          SegLow = (SEG_AL != 0);
    localparam bit          AnLow  = (AN_AL != 0);
    localparam logic [6:0]        SegOff = {7{SegLow}};
    localparam logic [DIGITS-1:0] AnOff  = {DIGITS{AnLow}};

    logic [PscW-1:0]     presc_q, presc_d;
    logic [IdxW-1:0]     idx_q, idx_d;
    logic [4*DIGITS-1:0] stage_data_q, stage_data_d, shadow_data_q, shadow_data_d;
    logic [DIGITS-1:0]   stage_dp_q, stage_dp_d, shadow_dp_q, shadow_dp_d;
    logic [DIGITS-1:0]   stage_blank_q, stage_blank_d, shadow_blank_q, shadow_blank_d;
    logic                pending_q, pending_d;
    logic [6:0]          seg_q, seg_d;
    logic                seg_dp_q, seg_dp_d;
    logic [DIGITS-1:0]   an_q, an_d;
    logic                frame_q, frame_d;

    logic                presc_wrap, idx_wrap, commit;
    logic                all_zero, dark;
    logic [DIGITS-1:0]   suppress;
    logic [3:0]          cur_nibble;
    logic [6:0]          cur_seg;

    assign presc_wrap = (presc_q == PscW'(SCAN_DIV - 1));
    assign idx_wrap   = (idx_q == IdxW'(DIGITS - 1));
    assign commit     = presc_wrap && idx_wrap && pending_q;
    assign cur_nibble = shadow_data_q[{idx_q, 2'b00} +: 4];

    hex_seg_decode u_dec (
        .nibble_i (cur_nibble),
        .seg_o    (cur_seg)
    );

    // Scan position and double-buffered display data.
    always_comb begin
        presc_d = presc_wrap ? '0 : presc_q + 1'b1;
        idx_d   = idx_q;
        if (presc_wrap) begin
            idx_d = idx_wrap ? '0 : idx_q + 1'b1;
        end

        shadow_data_d  = commit ? stage_data_q  : shadow_data_q;
        shadow_dp_d    = commit ? stage_dp_q    : shadow_dp_q;
        shadow_blank_d = commit ? stage_blank_q : shadow_blank_q;

        stage_data_d  = bus.load ? bus.data  : stage_data_q;
        stage_dp_d    = bus.load ? bus.dp    : stage_dp_q;
        stage_blank_d = bus.load ? bus.blank : stage_blank_q;

        pending_d = pending_q;
        if (bus.load) begin
            pending_d = 1'b1;
        end else if (commit) begin
            pending_d = 1'b0;
        end
    end

    // Zero run from the top digit downward; digit 0 is always shown.
    always_comb begin
        all_zero = bus.lz_en;
        suppress = '0;
        for (int i = int'(DIGITS) - 1; i >= 0; i--) begin
            all_zero    = all_zero && (shadow_data_q[4*i +: 4] == 4'h0);
            suppress[i] = all_zero && (i != 0);
        end
    end

    always_comb begin
        dark     = shadow_blank_q[idx_q] | suppress[idx_q];
        seg_d    = dark ? SegOff : seg_drive(cur_seg, SegLow);
        seg_dp_d = pol_bit(shadow_dp_q[idx_q], SegLow);
        an_d     = AnOff;
        if (presc_q >= PscW'(DEAD)) begin
            an_d[idx_q] = pol_bit(1'b1, AnLow);
        end
        frame_d = (presc_q == '0) && (idx_q == '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q        <= '0;
            idx_q          <= '0;
            stage_data_q   <= '0;
            stage_dp_q     <= '0;
            stage_blank_q  <= '0;
            shadow_data_q  <= '0;
            shadow_dp_q    <= '0;
            shadow_blank_q <= '0;
            pending_q      <= 1'b0;
            seg_q          <= SegOff;
            seg_dp_q       <= SegLow;
            an_q           <= AnOff;
            frame_q        <= 1'b0;
        end else begin
            presc_q        <= presc_d;
            idx_q          <= idx_d;
            stage_data_q   <= stage_data_d;
            stage_dp_q     <= stage_dp_d;
            stage_blank_q  <= stage_blank_d;
            shadow_data_q  <= shadow_data_d;
            shadow_dp_q    <= shadow_dp_d;
            shadow_blank_q <= shadow_blank_d;
            pending_q      <= pending_d;
            seg_q          <= seg_d;
            seg_dp_q       <= seg_dp_d;
            an_q           <= an_d;
            frame_q        <= frame_d;
        end
    end

    assign bus.pending = pending_q;
    assign bus.seg     = seg_q;
    assign bus.seg_dp  = seg_dp_q;
    assign bus.an      = an_q;
    assign bus.frame   = frame_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Randomized bench for seg7_scan_driver against a time-indexed display model.
module tb_seg7_scan_driver;
    localparam int ND   = 4;
    localparam int SD   = 4;
    localparam int DEAD = 1;
    localparam int FL   = ND * SD;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    seg7_scan_driver_if #(.DIGITS(ND)) bus ();

    seg7_scan_driver #(
        .DIGITS   (ND),
        .SCAN_DIV (SD),
        .DEAD     (DEAD),
        .SEG_AL   (1),
        .AN_AL    (1)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    logic [6:0] hex_tab [16] = '{
        7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111,
        7'b1100110, 7'b1101101, 7'b1111101, 7'b0000111,
        7'b1111111, 7'b1101111, 7'b1110111, 7'b1111100,
        7'b0111001, 7'b1011110, 7'b1111001, 7'b1110001
    };

    int n_vec = 0;
    int n_err = 0;

    // Model: cycles since reset release plus staged/shown words.
    int          t;
    logic [15:0] st_data, sh_data;
    logic [3:0]  st_dp, sh_dp, st_blank, sh_blank;
    bit          pend;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    task automatic model_reset();
        t = 0;
        st_data = '0; sh_data = '0;
        st_dp = '0; sh_dp = '0; st_blank = '0; sh_blank = '0;
        pend = 1'b0;
    endtask

    task automatic tick();
        int pos, dig;
        logic [3:0] e_an;
        logic [6:0] e_seg;
        logic e_dp, e_frame, dark;
        @(posedge clk);
        pos     = t % SD;
        dig     = (t / SD) % ND;
        e_an    = (pos < DEAD) ? 4'hF : ~(4'b0001 << dig);
        e_frame = (pos == 0) && (dig == 0);
        dark    = sh_blank[dig] || (bus.lz_en && dig != 0 && (sh_data >> (4 * dig)) == 16'h0);
        e_seg   = dark ? 7'h7F : ~hex_tab[sh_data[4*dig +: 4]];
        e_dp    = ~sh_dp[dig];
        if (((t + 1) % FL == 0) && pend) begin
            sh_data = st_data; sh_dp = st_dp; sh_blank = st_blank;
            pend = 1'b0;
        end
        if (bus.load) begin
            st_data = bus.data; st_dp = bus.dp; st_blank = bus.blank;
            pend = 1'b1;
        end
        t++;
        #1;
        check_eq("an", bus.an, e_an);
        check_eq("seg", bus.seg, e_seg);
        check_eq("seg_dp", bus.seg_dp, e_dp);
        check_eq("frame", bus.frame, e_frame);
        check_eq("pending", bus.pending, pend);
    endtask

    task automatic load_word(input logic [15:0] d, input logic [3:0] p, input logic [3:0] b);
        bus.data  = d;
        bus.dp    = p;
        bus.blank = b;
        bus.load  = 1'b1;
        tick();
        bus.load  = 1'b0;
    endtask

    initial begin
        rst_n     = 1'b0;
        bus.data  = '0;
        bus.dp    = '0;
        bus.blank = '0;
        bus.lz_en = 1'b0;
        bus.load  = 1'b0;
        model_reset();
        #12;
        check_eq("rst_an", bus.an, 4'hF);
        check_eq("rst_seg", bus.seg, 7'h7F);
        check_eq("rst_dp", bus.seg_dp, 1'b1);
        check_eq("rst_pend", bus.pending, 1'b0);
        check_eq("rst_frame", bus.frame, 1'b0);

        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check_eq("first_frame", bus.frame, 1'b1);
        check_eq("first_dead_an", bus.an, 4'hF);
        tick();
        check_eq("first_an", bus.an, 4'hE);

        repeat (3) tick();
        load_word(16'h12AF, 4'b0100, 4'b0000);
        repeat (2 * FL) tick();

        bus.lz_en = 1'b1;
        load_word(16'h0070, 4'b0000, 4'b0000);
        repeat (2 * FL) tick();

        bus.lz_en = 1'b0;
        load_word(16'h1111, 4'b0000, 4'b0000);
        repeat (3) tick();
        load_word(16'h2222, 4'b0000, 4'b0000);
        repeat (2 * FL) tick();

        // Second load lands exactly on the commit edge.
        load_word(16'h3333, 4'b0001, 4'b0000);
        while ((t + 1) % FL != 0) tick();
        load_word(16'h4444, 4'b1000, 4'b0000);
        check_eq("commit_pend", bus.pending, 1'b1);
        repeat (2 * FL) tick();

        load_word(16'h5555, 4'b1111, 4'b0000);
        repeat (2) tick();
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("async_an", bus.an, 4'hF);
        check_eq("async_seg", bus.seg, 7'h7F);
        check_eq("async_pend", bus.pending, 1'b0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (FL) tick();
        check_eq("post_rst_pend", bus.pending, 1'b0);

        for (int i = 0; i < 1500; i++) begin
            if (i % 100 == 0) bus.lz_en = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 5) == 0) begin
                bus.data  = 16'($urandom) >> $urandom_range(0, 16);
                bus.dp    = 4'($urandom);
                bus.blank = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
                bus.load  = 1'b1;
            end else begin
                bus.load  = 1'b0;
            end
            tick();
        end
        bus.load = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/seg7_scan_driver.md
SEG7_SCAN_DRIVER -- requirements
Module: seg7_scan_driver

Interface
REQ-001 SHALL have parameter DIGITS, default 4: number of multiplexed digits, range 1..8.
REQ-002 SHALL have parameter SCAN_DIV, default 50000: clk cycles per digit slot, minimum 2.
REQ-003 SHALL have parameter DEAD, default 2: anode-off cycles at the start of each slot, range 0..SCAN_DIV-1.
REQ-004 SHALL have parameter SEG_AL, default 1: 1 = segments active-low, 0 = active-high.
REQ-005 SHALL have parameter AN_AL, default 1: 1 = anodes active-low, 0 = active-high.
REQ-006 clk  in  1  single clock; all state on rising edge.
REQ-007 rst_n  in  1  asynchronous, active-low reset.
REQ-008 data  in  4*DIGITS  hex nibbles; nibble i (bits 4i+3:4i) drives digit i, where digit 0 is least significant.
REQ-009 dp  in  DIGITS  decimal-point enable per digit, 1 = lit.
REQ-010 blank  in  DIGITS  force-blank per digit, 1 = dark.
REQ-011 lz_en  in  1  leading-zero suppression enable.
REQ-012 load  in  1  single-cycle strobe; stages data/dp/blank.
REQ-013 seg  out  7  segments, bit0 = a … bit6 = g.
REQ-014 seg_dp  out  1  decimal-point segment.
REQ-015 an  out  DIGITS  digit enables, one-hot active.
REQ-016 pending  out  1  staged value not yet displayed.
REQ-017 frame  out  1  one-cycle pulse at the start of each digit-0 slot.

Function
REQ-018 Prescaler SHALL count 0..SCAN_DIV-1 and wrap to 0; digit index SHALL advance on wrap and cycle DIGITS-1 -> 0.
REQ-019 load SHALL copy data/dp/blank into the staging register and set pending=1 on the next edge.
REQ-020 A load while pending=1 SHALL overwrite the staging register; pending SHALL remain 1.
REQ-021 At the index wrap DIGITS-1 -> 0 with pending=1, the staging register SHALL copy to the shadow register and pending SHALL clear; the display SHALL read only the shadow register, so no frame ever mixes old and new data.
REQ-022 If load coincides with a commit, the shadow register SHALL take the old staged value, the staging register SHALL take the new value, and pending SHALL stay 1.
REQ-023 Hex decoding (active-high form, g..a): 0=0111111, 1=0000110, 2=1011011, 3=1001111, 4=1100110, 5=1101101, 6=1111101, 7=0000111, 8=1111111, 9=1101111, A=1110111, b=1111100, C=0111001, d=1011110, E=1111001, F=1110001; SEG_AL=1 SHALL invert these values.
REQ-024 With lz_en=1, the zero digits from DIGITS-1 downward to the first nonzero digit SHALL be blanked; digit 0 SHALL never be suppressed.
REQ-025 A blanked digit (blank bit or suppression) SHALL drive all segments inactive; its dp SHALL still follow the dp bit.
REQ-026 For prescaler < DEAD, all anodes SHALL be inactive; otherwise only the current digit's anode SHALL be active.
REQ-027 seg, seg_dp and an SHALL be registered and SHALL reflect the prescaler/index state one cycle later.
REQ-028 frame SHALL be registered and high for the one cycle in which the digit-0 slot begins (same latency as an).

Reset
REQ-029 rst_n=0 SHALL immediately force: prescaler=0, index=0, staging=0, shadow=0, pending=0, frame=0, all anodes inactive, seg and seg_dp inactive.
REQ-030 Reset asserted mid-frame SHALL discard staged data; after release the scan SHALL restart at digit 0 with prescaler 0.

Structure
REQ-031 The hex segment table and the polarity helper constants SHALL live in the shared package seg7_pkg.
REQ-032 Decoding SHALL be a combinational sub-module hex_seg_decode (4-bit in, 7-bit active-high out), instantiated once on the muxed nibble.

Verification
Use DIGITS=4, SCAN_DIV=4, DEAD=1, SEG_AL=1, AN_AL=1 unless stated.
REQ-033 Reset release -> an=1111, seg=1111111; the first frame pulse follows, then an=1110 after the dead cycle.
REQ-034 load data=16'h12AF, dp=4'b0100 mid-frame -> pending=1 until the next digit-0 slot; then digit 0 seg=0001110 (F), digit 1 seg=0001000 (A), digit 2 seg_dp=0, digit 2 shows 2, digit 3 shows 1.
REQ-035 lz_en=1, data=16'h0070 -> digits 3 and 2 are dark, digit 1 shows 7, digit 0 shows 0 (seg=1000000).
REQ-036 Two loads (16'h1111, then 16'h2222) within one frame -> only 2222 is displayed; 1111 never appears on seg.
REQ-037 load on the commit cycle -> the shadow register takes the prior staged value; pending stays 1; the new value appears one frame later.
REQ-038 Assert rst_n mid-slot with pending=1 -> outputs go inactive asynchronously; after release pending=0 and digit 0 shows 0.
